riscv_nn_apu_responder: RTL and testbench
=========================================

Name: riscv_nn_apu_responder

Overview:
APU-interconnect slave for the nn core's auxiliary processing unit. It accepts req/gnt requests from the core's APU dispatcher and returns results in order on valid/ready. Results come back with one of three latency classes: single-cycle, pipelined, or iterative multicycle. The block guarantees in-order return by withholding gnt from any request whose result could overtake an older one.

Parameters:
PIPE_DEPTH, 2, number of stages for pipelined ops; legal values are 1 to 3; result appears PIPE_DEPTH cycles after acceptance.
WIDTH, 32, operand and result width.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
apu_slave_req_i  in  1  request valid
apu_slave_gnt_o  out  1  request accepted this cycle
apu_slave_op_i  in  3  opcode (apu_op_e)
apu_slave_operands_i  in  3xWIDTH  operands a, b, c
apu_slave_valid_o  out  1  result valid
apu_slave_ready_i  in  1  master accepts result
apu_slave_result_o  out  WIDTH  result data
apu_slave_flags_o  out  1  illegal-op flag, qualified by valid
busy_o  out  1  any op inflight (pipe stage valid or divider not IDLE)

Behaviour:
- Reset: rst_i is sampled on clk_i. While asserted: gnt_o=0, valid_o=0, result_o=0, flags_o=0, busy_o=0. All pipe valids clear and the divider returns to IDLE; inflight results are discarded.
- Acceptance: a request is accepted when gnt_o=req_i&can_accept. gnt_o is combinational from req_i, op_i, internal state and ready_i.
- Ops and latency classes:
  - ADD (0): a+b. Class 1. Also used for every undefined opcode; an undefined opcode returns 0 with flags_o=1.
  - MAC (1): low WIDTH bits of a*b+c. Class 2.
  - DOTP4 (2): signed 4x8-bit dot product of a and b, plus c, wrapped to WIDTH. Class 2.
  - DIVU (3): unsigned a/b. Class 3. b=0 returns all-ones.
- Class 1 (single-cycle):
  - Granted only when ready_i=1, all pipe stages are empty and the divider is IDLE.
  - valid_o=1 and result_o are driven combinationally in the grant cycle.
- Class 2 (pipelined):
  - Granted when the divider is IDLE and the pipe is not stalled.
  - Accepts one op per cycle, back-to-back; the result is valid PIPE_DEPTH cycles after the accept cycle.
  - Stall: the last stage is valid and ready_i=0. During a stall all stages hold, result_o is stable, and gnt_o=0 for every op.
- Class 3 (divider FSM):
  - IDLE: DIVU is granted only if the pipe is empty. On grant, capture operands and go to BUSY with cnt=31.
  - BUSY: one restoring-division step per cycle. When cnt==0, go to DONE; otherwise cnt-1.
  - DONE: valid_o=1. On ready_i, go to IDLE.
  - Timing: accept at cycle T, valid at T+33.
  - gnt_o=0 for all ops while the FSM is in BUSY or DONE.
- Return priority:
  - At most one source may drive valid_o in any cycle: class-1 path, last pipe stage, or divider DONE. This is guaranteed by the grant rules.
  - The output mux selects by source valid. Otherwise result_o=0.
  - An assertion (simulation only) flags more than one source active.
- Simultaneous events:
  - A pipe result leaving with ready_i=1 while a new class-2 request is granted in the same cycle is legal. The pipe shifts.
  - A class-2 request while the divider is in DONE is not granted.
- Arithmetic: all results wrap modulo 2^WIDTH; there is no saturation.

Decomposition:
- Package riscv_nn_apu_resp_pkg:
  - apu_op_e (ADD=0, MAC=1, DOTP4=2, DIVU=3)
  - latency-class constants APU_LAT_SINGLE=1, APU_LAT_PIPE=2, APU_LAT_MULTI=3 (match the dispatcher's lat encoding)
  - function op2lat
  - divider state enum div_state_e {IDLE, BUSY, DONE}
- Sub-module riscv_nn_apu_divu: the iterative divider with its FSM and req/ready-style start/done. The responder keeps the op decode, the pipe and the grant/ordering logic.

Test Plan:
1. ADD a=5 b=7, ready_i=1, empty -> gnt_o and valid_o both in the same cycle, result 12, flags 0. Repeat with op=7 -> result 0, flags_o=1.
2. MAC (3,4,1), (2,2,2), (0xFFFFFFFF,1,0) on cycles 0,1,2 with PIPE_DEPTH=2 -> gnt every cycle, valid on cycles 2,3,4 with results 13, 6, 0xFFFFFFFF.
3. MAC at cycle 0, ADD requested from cycle 1 -> ADD gnt_o=0 until the MAC returns at cycle 2; ADD granted at cycle 3 (pipe empty); results returned in order.
4. DIVU a=100 b=7 accepted at T -> busy_o=1; any req during T+1..T+33 gets gnt=0; valid at T+33 with result 14. Then DIVU b=0 -> result 0xFFFFFFFF.
5. Two MACs inflight, ready_i=0 when the first reaches output -> valid_o held, result_o stable, gnt_o=0. ready_i=1 two cycles later -> both results drain on consecutive cycles.
6. rst_i=1 for one cycle at T+10 of a DIVU -> at T+11 valid_o=0 and busy_o=0; an ADD at T+11 is granted with a correct result; no DIVU result ever appears.

Source files
------------

// File: rtl/riscv_nn_apu_responder_pkg.sv
// Shared types for the nn-core APU responder.
//   apu_op_e      : opcodes issued by the APU dispatcher
//   APU_LAT_*     : latency classes, same encoding as the dispatcher's lat field
//   op2lat()      : maps an opcode to its latency class (undefined -> single)
//   div_state_e   : iterative divider FSM states
package riscv_nn_apu_resp_pkg;

    typedef enum logic [2:0] {
        APU_ADD   = 3'd0,
        APU_MAC   = 3'd1,
        APU_DOTP4 = 3'd2,
        APU_DIVU  = 3'd3
    } apu_op_e;

    localparam logic [1:0] APU_LAT_SINGLE = 2'd1;
    localparam logic [1:0] APU_LAT_PIPE   = 2'd2;
    localparam logic [1:0] APU_LAT_MULTI  = 2'd3;

    // Undefined opcodes are executed as ADD and therefore single-cycle.
    function automatic logic [1:0] op2lat(input logic [2:0] op);
        case (op)
            3'd1, 3'd2: return APU_LAT_PIPE;
            3'd3:       return APU_LAT_MULTI;
            default:    return APU_LAT_SINGLE;
        endcase
    endfunction

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/riscv_nn_apu_responder_divu.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
//   clk, rst  : clock, synchronous active-high reset
//   start     : capture dividend/divisor (only honoured while idle)
//   dividend  : numerator
//   divisor   : denominator; zero yields an all-ones quotient
//   idle      : FSM in IDLE, ready for a new start
//   done      : quotient valid (held until ready)
//   ready     : consumer takes the quotient, FSM returns to IDLE
//   quotient  : result
module riscv_nn_apu_divu
    import riscv_nn_apu_resp_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             idle,
    output logic             done,
    input  logic             ready,
    output logic [WIDTH-1:0] quotient
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] quo_q;   // dividend bits shift out the top, quotient bits in the bottom
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;

    // With a zero divisor every compare succeeds, giving the all-ones quotient.
    always_comb begin
        rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        q_bit     = (rem_shift >= {1'b0, dvs_q});
        rem_next  = q_bit ? (rem_shift - {1'b0, dvs_q}) : rem_shift;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (start)        state_d = DIV_BUSY;
            DIV_BUSY: if (cnt_q == '0)  state_d = DIV_DONE;
            DIV_DONE: if (ready)        state_d = DIV_IDLE;
            default:                    state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DIV_IDLE && start) begin
                cnt_q <= CNT_W'(WIDTH - 1);
                quo_q <= dividend;
                dvs_q <= divisor;
                rem_q <= '0;
            end else if (state_q == DIV_BUSY) begin
                rem_q <= rem_next;
                quo_q <= {quo_q[WIDTH-2:0], q_bit};
                if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign idle     = (state_q == DIV_IDLE);
    assign done     = (state_q == DIV_DONE);
    assign quotient = quo_q;

endmodule

// File: rtl/riscv_nn_apu_responder.sv
// APU interconnect slave: accepts req/gnt requests and returns results in
// order on valid/ready. Ordering is enforced purely by withholding gnt.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   apu_slave_req_i/gnt_o : request handshake (gnt combinational)
//   apu_slave_op_i        : opcode (apu_op_e)
//   apu_slave_operands_i  : operands [0]=a, [1]=b, [2]=c
//   apu_slave_valid_o     : result valid
//   apu_slave_ready_i     : master accepts result
//   apu_slave_result_o    : result data (0 when not valid)
//   apu_slave_flags_o     : illegal-opcode flag, qualified by valid
//   busy_o                : a pipe stage is valid or the divider is not idle
module riscv_nn_apu_responder
    import riscv_nn_apu_resp_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = 2,
    parameter int unsigned WIDTH      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  apu_slave_req_i,
    output logic                  apu_slave_gnt_o,
    input  logic [2:0]            apu_slave_op_i,
    input  logic [2:0][WIDTH-1:0] apu_slave_operands_i,
    output logic                  apu_slave_valid_o,
    input  logic                  apu_slave_ready_i,
    output logic [WIDTH-1:0]      apu_slave_result_o,
    output logic                  apu_slave_flags_o,
    output logic                  busy_o
);

    logic [WIDTH-1:0]      op_a, op_b, op_c;
    logic [1:0]            lat;
    logic                  op_legal;
    logic [WIDTH-1:0]      single_res;
    logic [WIDTH-1:0]      pipe_res;

    logic [PIPE_DEPTH-1:0] pipe_vld;
    logic [WIDTH-1:0]      pipe_data [PIPE_DEPTH];
    logic                  pipe_empty;
    logic                  last_vld;
    logic                  stall;

    logic                  gnt;
    logic                  single_vld;
    logic                  pipe_in;
    logic                  div_start;
    logic                  div_idle;
    logic                  div_done;
    logic [WIDTH-1:0]      div_result;

    assign op_a     = apu_slave_operands_i[0];
    assign op_b     = apu_slave_operands_i[1];
    assign op_c     = apu_slave_operands_i[2];
    assign lat      = op2lat(apu_slave_op_i);
    assign op_legal = (apu_slave_op_i <= 3'd3);

    function automatic logic [WIDTH-1:0] dotp4(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0]   acc;
        logic signed [15:0] x, y, p;
        acc = c;
        for (int unsigned i = 0; i < 4; i++) begin
            x   = 16'($signed(a[8*i +: 8]));
            y   = 16'($signed(b[8*i +: 8]));
            p   = x * y;
            acc = acc + {{(WIDTH-16){p[15]}}, p};
        end
        return acc;
    endfunction

    always_comb begin
        single_res = '0;
        if (apu_slave_op_i == 3'(APU_ADD)) single_res = op_a + op_b;
        pipe_res = (apu_slave_op_i == 3'(APU_DOTP4)) ? dotp4(op_a, op_b, op_c)
                                                     : op_a * op_b + op_c;
    end

    assign last_vld   = pipe_vld[PIPE_DEPTH-1];
    assign pipe_empty = (pipe_vld == '0);
    assign stall      = last_vld && !apu_slave_ready_i;

    // Class 1 needs everything drained so it cannot overtake; class 3 needs
    // the pipe empty; class 2 only needs the divider idle and a moving pipe.
    always_comb begin
        gnt = 1'b0;
        if (!rst_i && apu_slave_req_i) begin
            case (lat)
                APU_LAT_SINGLE: gnt = apu_slave_ready_i && pipe_empty && div_idle;
                APU_LAT_PIPE:   gnt = div_idle && !stall;
                APU_LAT_MULTI:  gnt = div_idle && pipe_empty;
                default:        gnt = 1'b0;
            endcase
        end
    end

    assign single_vld = gnt && (lat == APU_LAT_SINGLE);
    assign pipe_in    = gnt && (lat == APU_LAT_PIPE);
    assign div_start  = gnt && (lat == APU_LAT_MULTI);

    // The whole pipe advances every non-stalled cycle, so a result at the
    // last stage leaves exactly when a new op may enter stage 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_vld <= '0;
        end else if (!stall) begin
            pipe_vld[0] <= pipe_in;
            for (int unsigned i = 1; i < PIPE_DEPTH; i++) pipe_vld[i] <= pipe_vld[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!stall) begin
            pipe_data[0] <= pipe_res;
            for (int unsigned i = 1; i < PIPE_DEPTH; i++) pipe_data[i] <= pipe_data[i-1];
        end
    end

    riscv_nn_apu_divu #(.WIDTH(WIDTH)) u_divu (
        .clk      (clk_i),
        .rst      (rst_i),
        .start    (div_start),
        .dividend (op_a),
        .divisor  (op_b),
        .idle     (div_idle),
        .done     (div_done),
        .ready    (apu_slave_ready_i),
        .quotient (div_result)
    );

    always_comb begin
        apu_slave_valid_o  = 1'b0;
        apu_slave_result_o = '0;
        apu_slave_flags_o  = 1'b0;
        if (!rst_i) begin
            if (single_vld) begin
                apu_slave_valid_o  = 1'b1;
                apu_slave_result_o = single_res;
                apu_slave_flags_o  = !op_legal;
            end else if (last_vld) begin
                apu_slave_valid_o  = 1'b1;
                apu_slave_result_o = pipe_data[PIPE_DEPTH-1];
            end else if (div_done) begin
                apu_slave_valid_o  = 1'b1;
                apu_slave_result_o = div_result;
            end
        end
    end

    assign apu_slave_gnt_o = gnt;
    assign busy_o          = !rst_i && (!pipe_empty || !div_idle);

    a_one_source : assert property (@(posedge clk_i) disable iff (rst_i)
                                    $onehot0({single_vld, last_vld, div_done}));

endmodule

// File: tb/tb_riscv_nn_apu_responder.sv
module tb_riscv_nn_apu_responder;
    import riscv_nn_apu_resp_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned PD = 2;

    logic              clk = 1'b0;
    logic              rst, req, gnt, valid, ready, flags, busy;
    logic [2:0]        op;
    logic [2:0][W-1:0] operands;
    logic [W-1:0]      result;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    logic [32:0] exp_q[$];

    riscv_nn_apu_responder #(.PIPE_DEPTH(PD), .WIDTH(W)) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .apu_slave_req_i      (req),
        .apu_slave_gnt_o      (gnt),
        .apu_slave_op_i       (op),
        .apu_slave_operands_i (operands),
        .apu_slave_valid_o    (valid),
        .apu_slave_ready_i    (ready),
        .apu_slave_result_o   (result),
        .apu_slave_flags_o    (flags),
        .busy_o               (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end of the test");
        $fatal(1, "timeout");
    end

    // Reference results: {illegal_flag, result}
    function automatic logic [32:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c);
        longint s;
        byte    x, y;
        case (o)
            3'd0: return {1'b0, a + b};
            3'd1: begin
                s = longint'(a) * longint'(b) + longint'(c);
                return {1'b0, s[31:0]};
            end
            3'd2: begin
                s = longint'(c);
                for (int i = 0; i < 4; i++) begin
                    x = a[8*i +: 8];
                    y = b[8*i +: 8];
                    s = s + longint'(x) * longint'(y);
                end
                return {1'b0, s[31:0]};
            end
            3'd3: return (b == 0) ? {1'b0, 32'hFFFF_FFFF} : {1'b0, a / b};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive at posedge+1, then settle so checks happen mid-cycle.
    task automatic apply(input logic r, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c, input logic rdy);
        req = r; op = o; operands[0] = a; operands[1] = b; operands[2] = c; ready = rdy;
        #1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gv(input string tag, input logic g, input logic v);
        check({tag, "_gnt"}, gnt, g);
        check({tag, "_valid"}, valid, v);
    endtask

    initial begin
        logic [32:0] e1, e2, e3;
        rst = 1'b1;
        apply(1, APU_ADD, 5, 7, 0, 1);
        check("reset_gnt", gnt, 0);
        check("reset_valid", valid, 0);
        check("reset_result", result, 0);
        check("reset_flags", flags, 0);
        check("reset_busy", busy, 0);
        next(); next();
        rst = 1'b0;

        // 1: single-cycle ADD and undefined opcode
        apply(1, APU_ADD, 5, 7, 0, 1);
        chk_gv("add", 1, 1);
        check("add_result", result, 12);
        check("add_flags", flags, 0);
        next();
        apply(1, 3'd7, 5, 7, 0, 1);
        chk_gv("illegal", 1, 1);
        check("illegal_result", result, 0);
        check("illegal_flags", flags, 1);
        next();
        apply(0, APU_ADD, 0, 0, 0, 1);
        check("idle_valid", valid, 0);
        next();

        // 2: back-to-back MACs
        apply(1, APU_MAC, 3, 4, 1, 1);              chk_gv("mac_c0", 1, 0); next();
        apply(1, APU_MAC, 2, 2, 2, 1);              chk_gv("mac_c1", 1, 0); next();
        apply(1, APU_MAC, 32'hFFFF_FFFF, 1, 0, 1);  chk_gv("mac_c2", 1, 1);
        check("mac_r0", result, 13); next();
        apply(0, APU_MAC, 0, 0, 0, 1);              check("mac_c3_valid", valid, 1);
        check("mac_r1", result, 6); next();
        apply(0, APU_MAC, 0, 0, 0, 1);              check("mac_c4_valid", valid, 1);
        check("mac_r2", result, 32'hFFFF_FFFF); next();
        apply(0, APU_MAC, 0, 0, 0, 1);              check("mac_c5_valid", valid, 0);
        check("mac_c5_busy", busy, 0); next();

        // 3: ADD held off behind an inflight MAC; DOTP4 corner
        apply(1, APU_MAC, 3, 4, 1, 1);  chk_gv("ord_c0", 1, 0); next();
        apply(1, APU_ADD, 1, 2, 0, 1);  chk_gv("ord_c1", 0, 0); next();
        apply(1, APU_ADD, 1, 2, 0, 1);  chk_gv("ord_c2", 0, 1);
        check("ord_mac_result", result, 13); next();
        apply(1, APU_ADD, 1, 2, 0, 1);  chk_gv("ord_c3", 1, 1);
        check("ord_add_result", result, 3); next();
        apply(1, APU_DOTP4, 32'h01FF_02FE, 32'h0304_0506, 10, 1); chk_gv("dotp_c0", 1, 0); next();
        apply(0, APU_ADD, 0, 0, 0, 1); next();
        apply(0, APU_ADD, 0, 0, 0, 1); check("dotp_valid", valid, 1);
        check("dotp_result", result, 7); next();

        // 4: divider latency and grant blocking
        apply(1, APU_DIVU, 100, 7, 0, 1); chk_gv("div_accept", 1, 0); next();
        for (int k = 1; k <= 32; k++) begin
            apply(1, (k % 2) ? APU_MAC : APU_ADD, 1, 1, 1, 1);
            chk_gv("div_busy", 0, 0);
            check("div_busy_flag", busy, 1);
            next();
        end
        apply(1, APU_MAC, 1, 1, 1, 1);  chk_gv("div_done", 0, 1);
        check("div_result", result, 14);
        check("div_flags", flags, 0); next();
        apply(0, APU_ADD, 0, 0, 0, 1);  check("div_after_valid", valid, 0);
        check("div_after_busy", busy, 0); next();
        apply(1, APU_DIVU, 5, 0, 0, 1); chk_gv("div0_accept", 1, 0); next();
        for (int k = 1; k <= 32; k++) begin
            apply(0, APU_ADD, 0, 0, 0, 1);
            check("div0_wait_valid", valid, 0);
            next();
        end
        apply(0, APU_ADD, 0, 0, 0, 1);  check("div0_valid", valid, 1);
        check("div0_result", result, 32'hFFFF_FFFF); next();

        // 5: stall with two MACs inflight
        e1 = model(APU_MAC, 32'h1234_5678, 32'h9, 32'h77);
        e2 = model(APU_MAC, 32'hDEAD_BEEF, 32'h3, 32'h1);
        e3 = model(APU_MAC, 32'h10, 32'h10, 32'h10);
        apply(1, APU_MAC, 32'h1234_5678, 32'h9, 32'h77, 1); chk_gv("stall_c0", 1, 0); next();
        apply(1, APU_MAC, 32'hDEAD_BEEF, 32'h3, 32'h1, 1);  chk_gv("stall_c1", 1, 0); next();
        apply(1, APU_MAC, 1, 1, 1, 0); chk_gv("stall_c2", 0, 1);
        check("stall_c2_result", result, e1[31:0]); next();
        apply(1, APU_ADD, 1, 1, 1, 0); chk_gv("stall_c3", 0, 1);
        check("stall_c3_result", result, e1[31:0]); next();
        apply(1, APU_MAC, 32'h10, 32'h10, 32'h10, 1); chk_gv("stall_c4", 1, 1);
        check("stall_c4_result", result, e1[31:0]); next();
        apply(0, APU_ADD, 0, 0, 0, 1); check("stall_c5_valid", valid, 1);
        check("stall_c5_result", result, e2[31:0]); next();
        apply(0, APU_ADD, 0, 0, 0, 1); check("stall_c6_valid", valid, 1);
        check("stall_c6_result", result, e3[31:0]); next();
        apply(0, APU_ADD, 0, 0, 0, 1); check("stall_c7_valid", valid, 0); next();

        // 6: reset in the middle of a divide
        apply(1, APU_DIVU, 1000, 3, 0, 1); chk_gv("rdiv_accept", 1, 0); next();
        for (int k = 1; k < 10; k++) begin apply(0, APU_ADD, 0, 0, 0, 1); next(); end
        rst = 1'b1;
        apply(0, APU_ADD, 0, 0, 0, 1);
        check("rdiv_rst_valid", valid, 0);
        check("rdiv_rst_busy", busy, 0); next();
        rst = 1'b0;
        apply(1, APU_ADD, 8, 9, 0, 1);
        check("rdiv_post_busy", busy, 0);
        chk_gv("rdiv_add", 1, 1);
        check("rdiv_add_result", result, 17); next();
        for (int k = 0; k < 40; k++) begin
            apply(0, APU_ADD, 0, 0, 0, 1);
            check("rdiv_no_result", valid, 0);
            next();
        end

        // Random traffic against an in-order scoreboard
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb, rc;
            int unsigned n;
            ro = ($urandom % 5 == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom % 4);
            ra = $urandom;
            rc = $urandom;
            rb = ($urandom % 8 == 0) ? 32'h0 :
                 (($urandom % 2) ? $urandom : 32'($urandom_range(1, 300)));
            apply(($urandom % 4) != 0, ro, ra, rb, rc, ($urandom % 4) != 0);
            check("rand_gnt_without_req", gnt & ~req, 0);
            if (gnt) exp_q.push_back(model(ro, ra, rb, rc));
            n = exp_q.size();
            check("rand_valid_nothing_pending", valid && (n == 0), 0);
            if (valid && n > 0) begin
                check("rand_result", {flags, result}, exp_q[0]);
                if (ready) void'(exp_q.pop_front());
            end
            next();
        end
        for (int k = 0; k < 60 && exp_q.size() > 0; k++) begin
            apply(0, APU_ADD, 0, 0, 0, 1);
            if (valid) begin
                check("drain_result", {flags, result}, exp_q[0]);
                void'(exp_q.pop_front());
            end
            next();
        end
        check("drain_left", exp_q.size(), 0);
        apply(0, APU_ADD, 0, 0, 0, 1);
        check("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
